// File: rtl/exec_issue_unit_pkg.sv
// exec_issue_unit_pkg: state encodings and opcode constants shared by the execution issue unit
package exec_issue_unit_pkg;
  typedef enum logic [1:0] {EXU_IDLE = 2'd0, EXU_RUN = 2'd1, EXU_RUN_PEND = 2'd2} exu_state_e;
  localparam logic [15:0] NOP = 16'h0000;
  localparam logic [15:0] RET = 16'h0013;
endpackage

// File: rtl/exec_issue_unit_slot.sv
// exu_slot: enable-loaded instruction register holding {op, A, B, dest}
module exu_slot #(
  parameter int W = 8
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge Clock)
    if (Reset) q <= '0;
    else if (en) q <= d;
endmodule

// File: rtl/exec_issue_unit.sv
// exec_issue_unit: issues decoded instructions to the ALU with one pending slot, write-back, branch flush and watchdog
module exec_issue_unit
  import exec_issue_unit_pkg::*;
#(
  parameter int LANES              = 3,
  parameter int WIDTH              = 32,
  parameter int OP_WIDTH           = 16,
  parameter int DATA_ADDRESS_WIDTH = 16,
  parameter int ROM_ADDRESS_WIDTH  = 16,
  parameter int TIMEOUT_CYCLES     = 255
) (
  input  logic                          Clock,
  input  logic                          Reset,
  input  logic                          iDecodeDone,
  input  logic [OP_WIDTH-1:0]           iOperation,
  input  logic [LANES*WIDTH-1:0]        iSource0,
  input  logic [LANES*WIDTH-1:0]        iSource1,
  input  logic [DATA_ADDRESS_WIDTH-1:0] iDestination,
  output logic                          oExeLatchedValues,
  output logic                          oBusy,
  output logic                          oTriggerALU,
  output logic [OP_WIDTH-1:0]           oALUOperation,
  output logic [LANES*WIDTH-1:0]        oALUChannelA,
  output logic [LANES*WIDTH-1:0]        oALUChannelB,
  input  logic [LANES*WIDTH-1:0]        iALUResult,
  input  logic                          iALUOutputReady,
  input  logic                          iBranchTaken,
  input  logic                          iBranchNotTaken,
  output logic                          oRAMWriteEnable,
  output logic [DATA_ADDRESS_WIDTH-1:0] oRAMWriteAddress,
  output logic [LANES*WIDTH-1:0]        oRAMWriteData,
  output logic                          oJumpFlag,
  output logic [ROM_ADDRESS_WIDTH-1:0]  oJumpIp,
  output logic [DATA_ADDRESS_WIDTH-1:0] oLastDestination,
  output logic                          oLastDestinationValid,
  output logic                          oTimeout
);
  localparam int DW = LANES * WIDTH;
  localparam int SW = OP_WIDTH + 2 * DW + DATA_ADDRESS_WIDTH;
  localparam int CW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  exu_state_e state;
  logic [SW-1:0] dec_w, pend_w, iss_w;
  logic [OP_WIDTH-1:0] iss_op;
  logic [DATA_ADDRESS_WIDTH-1:0] iss_dest;
  logic [CW-1:0] cnt;
  logic trig, active, accept, rdy_act, load_issue, load_pend, busy_wait, wd_hit;
  assign dec_w = {iOperation, iSource1, iSource0, iDestination};
  assign {iss_op, oALUChannelA, oALUChannelB, iss_dest} = iss_w;
  assign active = state != EXU_IDLE;
  assign oBusy = state == EXU_RUN_PEND;
  assign accept = iDecodeDone & ~oBusy;
  assign rdy_act = iALUOutputReady & active;
  // a taken branch flushes whatever would have been issued next
  assign load_issue = (~active & accept) | (rdy_act & ~iBranchTaken & (oBusy | accept));
  assign load_pend = (state == EXU_RUN) & ~iALUOutputReady & accept;
  assign busy_wait = active & ~iALUOutputReady;
  assign wd_hit = (TIMEOUT_CYCLES != 0) && busy_wait && (cnt == CW'(TIMEOUT_CYCLES - 1));
  exu_slot #(.W(SW)) u_pend (
    .Clock(Clock), .Reset(Reset), .en(load_pend), .d(dec_w), .q(pend_w)
  );
  exu_slot #(.W(SW)) u_issue (
    .Clock(Clock), .Reset(Reset), .en(load_issue), .d(oBusy ? pend_w : dec_w), .q(iss_w)
  );
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state    <= EXU_IDLE;
      trig     <= 1'b0;
      cnt      <= '0;
      oTimeout <= 1'b0;
    end else begin
      trig <= load_issue;
      if (load_issue) cnt <= '0;
      else if (busy_wait) cnt <= cnt + CW'(1);
      if (wd_hit) begin
        state    <= EXU_IDLE;
        oTimeout <= 1'b1;
      end else if (load_issue) state <= EXU_RUN;
      else if (rdy_act) state <= EXU_IDLE;
      else if (load_pend) state <= EXU_RUN_PEND;
    end
  end
  assign oExeLatchedValues = accept;
  assign oTriggerALU = trig;
  assign oALUOperation = iss_op;
  assign oRAMWriteEnable = rdy_act & (~(iBranchTaken | iBranchNotTaken) | (iss_op == OP_WIDTH'(RET)))
                         & (iss_op != OP_WIDTH'(NOP));
  assign oRAMWriteAddress = iss_dest;
  assign oRAMWriteData = iALUResult;
  assign oJumpFlag = rdy_act & iBranchTaken;
  assign oJumpIp = iss_dest[ROM_ADDRESS_WIDTH-1:0];
  assign oLastDestination = iss_dest;
  assign oLastDestinationValid = active;
endmodule

// File: tb/tb_exec_issue_unit.sv
// tb_exec_issue_unit: directed and randomized checks of exec_issue_unit against an in-flight queue model
module tb_exec_issue_unit;
  import exec_issue_unit_pkg::*;
  localparam int TO = 8;
  localparam logic [15:0] ADD = 16'h0001, SUB = 16'h0002, OP4 = 16'h0004, JMP = 16'h0020;
  typedef struct packed {
    logic [15:0] op;
    logic [95:0] a;
    logic [95:0] b;
    logic [15:0] dest;
  } ins_t;
  logic Clock = 1'b0;
  logic Reset, dd, rdy, bt, bnt;
  logic [15:0] op, dest;
  logic [95:0] s0, s1, res;
  logic lat, busy, trg, wen, jmp, lvalid, tmo_o;
  logic [15:0] aop, waddr, jip, ldest;
  logic [95:0] cha, chb, wdata;
  ins_t q[$];
  ins_t last;
  int wait_cnt = 0;
  bit tmo = 0, trig_exp = 0;
  int checks = 0, errors = 0;
  always #5 Clock = ~Clock;
  exec_issue_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .Clock(Clock), .Reset(Reset), .iDecodeDone(dd), .iOperation(op), .iSource0(s0), .iSource1(s1),
    .iDestination(dest), .oExeLatchedValues(lat), .oBusy(busy), .oTriggerALU(trg),
    .oALUOperation(aop), .oALUChannelA(cha), .oALUChannelB(chb), .iALUResult(res),
    .iALUOutputReady(rdy), .iBranchTaken(bt), .iBranchNotTaken(bnt), .oRAMWriteEnable(wen),
    .oRAMWriteAddress(waddr), .oRAMWriteData(wdata), .oJumpFlag(jmp), .oJumpIp(jip),
    .oLastDestination(ldest), .oLastDestinationValid(lvalid), .oTimeout(tmo_o)
  );
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic cmp_model();
    bit act = q.size() > 0;
    bit w = rdy && act && (!(bt || bnt) || last.op == RET) && last.op != NOP;
    chk("accept", lat, dd && q.size() < 2);
    chk("busy", busy, q.size() == 2);
    chk("trigger", trg, trig_exp);
    chk("alu_op", aop, last.op);
    chk("alu_a", cha, last.a);
    chk("alu_b", chb, last.b);
    chk("wen", wen, w);
    chk("waddr", waddr, last.dest);
    chk("wdata", wdata, res);
    chk("jump", jmp, rdy && bt && act);
    chk("jump_ip", jip, last.dest);
    chk("last_dest", ldest, last.dest);
    chk("last_valid", lvalid, act);
    chk("timeout", tmo_o, tmo);
  endtask
  task automatic cyc(input logic r, input logic d, input logic [15:0] o, input logic [95:0] a0,
                     input logic [95:0] a1, input logic [15:0] ds, input logic rd, input logic b_t,
                     input logic b_n, input logic [95:0] rs);
    Reset = r; dd = d; op = o; s0 = a0; s1 = a1; dest = ds;
    rdy = rd; bt = b_t; bnt = b_n; res = rs;
    #1 cmp_model();
  endtask
  task automatic idle();
    cyc(0, 0, 16'h0, 96'h0, 96'h0, 16'h0, 0, 0, 0, 96'h0);
  endtask
  task automatic dec(input logic [15:0] o, input logic [95:0] a0, input logic [95:0] a1, input logic [15:0] ds);
    cyc(0, 1, o, a0, a1, ds, 0, 0, 0, 96'h0);
  endtask
  task automatic done(input logic b_t, input logic b_n, input logic [95:0] rs);
    cyc(0, 0, 16'h0, 96'h0, 96'h0, 16'h0, 1, b_t, b_n, rs);
  endtask
  // model: queue of accepted instructions, head is the one the ALU is working on
  task automatic adv();
    ins_t inp = '{op, s1, s0, dest};
    bit acc = dd && q.size() < 2;
    @(posedge Clock);
    if (Reset) begin
      q.delete(); last = '0; tmo = 0; trig_exp = 0; wait_cnt = 0;
    end else begin
      trig_exp = 0;
      if (q.size() == 0) begin
        if (acc) begin q.push_back(inp); last = inp; trig_exp = 1; wait_cnt = 0; end
      end else if (rdy) begin
        void'(q.pop_front());
        if (acc) q.push_back(inp);
        if (bt) q.delete();
        else if (q.size() > 0) begin last = q[0]; trig_exp = 1; wait_cnt = 0; end
      end else begin
        wait_cnt++;
        if (acc) q.push_back(inp);
        if (wait_cnt == TO) begin q.delete(); tmo = 1; end
      end
    end
    @(negedge Clock);
  endtask
  bit slow;
  logic r_i, rd_i, d_i;
  int k, br;
  logic [15:0] o_i;
  initial begin
    last = '0;
    Reset = 1; dd = 0; op = 0; s0 = 0; s1 = 0; dest = 0; rdy = 0; bt = 0; bnt = 0; res = 0;
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    idle();
    chk("rst_trigger", trg, 0); chk("rst_busy", busy, 0); chk("rst_valid", lvalid, 0);
    chk("rst_timeout", tmo_o, 0); chk("rst_aluop", aop, 0);
    adv();
    // single ADD
    dec(ADD, {32'd1, 32'd2, 32'd3}, {32'd4, 32'd5, 32'd6}, 16'h0010);
    chk("add_accept", lat, 1);
    adv();
    idle();
    chk("add_trigger", trg, 1); chk("add_op", aop, ADD);
    chk("add_a", cha, {32'd4, 32'd5, 32'd6}); chk("add_b", chb, {32'd1, 32'd2, 32'd3});
    adv(); idle(); adv(); idle(); adv();
    done(0, 0, {32'd5, 32'd7, 32'd9});
    chk("add_wen", wen, 1); chk("add_waddr", waddr, 16'h0010); chk("add_wdata", wdata, {32'd5, 32'd7, 32'd9});
    adv();
    idle();
    chk("add_idle", lvalid, 0); chk("add_nowrite", wen, 0);
    adv();
    // overlap through the pending slot
    dec(ADD, 96'h11, 96'h22, 16'h0020); adv();
    dec(SUB, 96'h33, 96'h44, 16'h0021);
    chk("ovl_trigger", trg, 1); chk("ovl_accept2", lat, 1);
    adv();
    dec(OP4, 96'h55, 96'h66, 16'h0022);
    chk("ovl_busy", busy, 1); chk("ovl_stall", lat, 0);
    adv();
    cyc(0, 1, OP4, 96'h55, 96'h66, 16'h0022, 1, 0, 0, 96'hAAAA);
    chk("ovl_wen1", wen, 1); chk("ovl_waddr1", waddr, 16'h0020); chk("ovl_stall2", lat, 0);
    adv();
    idle();
    chk("ovl_trigger2", trg, 1); chk("ovl_op2", aop, SUB); chk("ovl_dest2", ldest, 16'h0021);
    adv();
    done(0, 0, 96'hBBBB);
    chk("ovl_waddr2", waddr, 16'h0021); chk("ovl_wen2", wen, 1);
    adv();
    // taken branch squashes the pending instruction
    dec(JMP, 96'h0, 96'h0, 16'h0040); adv();
    dec(ADD, 96'h7, 96'h8, 16'h0050); adv();
    done(1, 0, 96'h0);
    chk("br_jump", jmp, 1); chk("br_ip", jip, 16'h0040); chk("br_nowrite", wen, 0);
    adv();
    idle();
    chk("br_notrigger", trg, 0); chk("br_idle", lvalid, 0); chk("br_notbusy", busy, 0);
    adv();
    // NOP and RET
    dec(NOP, 96'h1, 96'h2, 16'h0060); adv(); idle(); adv();
    done(0, 0, 96'h9);
    chk("nop_nowrite", wen, 0);
    adv();
    dec(RET, 96'h1, 96'h2, 16'h0070); adv(); idle(); adv();
    done(1, 0, 96'h77);
    chk("ret_wen", wen, 1); chk("ret_jump", jmp, 1); chk("ret_ip", jip, 16'h0070);
    adv();
    // watchdog
    dec(ADD, 96'h3, 96'h4, 16'h0080); adv();
    for (int i = 0; i < TO; i++) begin
      idle();
      if (i == 0) chk("wd_trigger", trg, 1);
      if (i == TO - 1) chk("wd_not_yet", tmo_o, 0);
      adv();
    end
    idle();
    chk("wd_timeout", tmo_o, 1); chk("wd_idle", lvalid, 0);
    adv();
    dec(ADD, 96'h5, 96'h6, 16'h0090);
    chk("wd_accept", lat, 1);
    adv();
    idle();
    chk("wd_trigger2", trg, 1); chk("wd_sticky", tmo_o, 1);
    adv();
    done(0, 0, 96'h1); adv();
    // reset while RUN_PEND
    dec(ADD, 96'h1, 96'h1, 16'h00A0); adv();
    dec(SUB, 96'h2, 96'h2, 16'h00A1); adv();
    cyc(1, 0, 16'h0, 96'h0, 96'h0, 16'h0, 0, 0, 0, 96'h0);
    chk("rp_busy", busy, 1);
    adv();
    done(0, 0, 96'h1234);
    chk("rp_nowrite", wen, 0); chk("rp_trigger", trg, 0); chk("rp_valid", lvalid, 0);
    chk("rp_timeout", tmo_o, 0); chk("rp_aluop", aop, 0); chk("rp_dest", ldest, 0); chk("rp_busy0", busy, 0);
    adv();
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      slow = ((i / 250) % 2) == 1;
      r_i = $urandom_range(0, 299) == 0;
      rd_i = !trig_exp && ($urandom_range(0, slow ? 13 : 2) == 0);
      d_i = $urandom_range(0, 2) != 0;
      k = $urandom_range(0, 4);
      br = $urandom_range(0, 3);
      o_i = k == 0 ? NOP : k == 1 ? RET : k == 2 ? ADD : k == 3 ? JMP : 16'($urandom);
      cyc(r_i, d_i, o_i, {$urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom}, 16'($urandom),
          rd_i, br == 1, br == 2, {$urandom, $urandom, $urandom});
      adv();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
